// File: rtl/vend_stock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vend_stock_ctrl
// Purpose  : Inventory controller for the vending machine. Accepts one
//            query / dispense / restock / clear request at a time over a
//            valid/ready handshake, performs a read-modify-write of the
//            slot's stock count in the external slot RAM and returns a
//            one-cycle response carrying the new count and a status bit.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req_valid_i/ready_o - request handshake
//            req_op_i            - 00 query, 01 dispense, 10 restock, 11 clear
//            req_slot_i          - target slot
//            req_qty_i           - restock amount
//            rsp_valid_o         - one-cycle response strobe
//            rsp_count_o         - slot count after the operation
//            rsp_ok_o            - 1 = succeeded / no saturation
//            ram_we_o, ram_re_o, ram_addr_o, ram_wdata_o, ram_rdata_i
//                                - slot RAM port (read data one cycle late)
//            low_stock_o         - only with VEND_LOW_STOCK_EN defined
// Config   : VEND_LOW_STOCK_EN   - adds low_stock_o and LOW_THRESH
// Revision : 1.0 - initial release
// ============================================================================
module vend_stock_ctrl #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 4
`ifdef VEND_LOW_STOCK_EN
   ,
   parameter int LOW_THRESH = 2
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [1:0]        req_op_i,
   input  logic [ADDR_W-1:0] req_slot_i,
   input  logic [DATA_W-1:0] req_qty_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_count_o,
   output logic              rsp_ok_o,
   output logic              ram_we_o,
   output logic              ram_re_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [DATA_W-1:0] ram_rdata_i
`ifdef VEND_LOW_STOCK_EN
   ,
   output logic              low_stock_o
`endif
);

   localparam logic [1:0]        c_OP_QUERY   = 2'b00;
   localparam logic [1:0]        c_OP_DISP    = 2'b01;
   localparam logic [1:0]        c_OP_RESTOCK = 2'b10;
   localparam logic [1:0]        c_OP_CLEAR   = 2'b11;
   localparam logic [DATA_W-1:0] c_MAX        = {DATA_W{1'b1}};
   localparam logic [DATA_W-1:0] c_ONE        = DATA_W'(1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CAP  = 3'd2,
      S_WR   = 3'd3,
      S_RSP  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [DATA_W-1:0] qty_q, qty_d;
   logic [DATA_W-1:0] res_count_q, res_count_d;  // result waiting out the WR cycle
   logic              res_ok_q, res_ok_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_count_q, rsp_count_d;
   logic              rsp_ok_q, rsp_ok_d;
   logic              ram_we_q, ram_we_d;
   logic              ram_re_q, ram_re_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
`ifdef VEND_LOW_STOCK_EN
   localparam logic [DATA_W-1:0] c_LOW_THRESH = DATA_W'(LOW_THRESH);
   logic              low_stock_q, low_stock_d;
`endif

   // One extra bit so restock overflow is visible as the carry.
   logic [DATA_W:0]   w_sum;
   assign w_sum = {1'b0, ram_rdata_i} + {1'b0, qty_q};

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      qty_d       = qty_q;
      res_count_d = res_count_q;
      res_ok_d    = res_ok_q;
      rsp_valid_d = 1'b0;
      rsp_count_d = rsp_count_q;
      rsp_ok_d    = rsp_ok_q;
      ram_we_d    = 1'b0;
      ram_re_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               op_d       = req_op_i;
               qty_d      = req_qty_i;
               ram_addr_d = req_slot_i;
               if (req_op_i == c_OP_CLEAR) begin
                  // Clear needs no read: go straight to the write.
                  state_d     = S_WR;
                  ram_we_d    = 1'b1;
                  ram_wdata_d = '0;
                  res_count_d = '0;
                  res_ok_d    = 1'b1;
               end else begin
                  state_d  = S_RD;
                  ram_re_d = 1'b1;
               end
            end
         end
         S_RD: begin
            state_d = S_CAP;
         end
         S_CAP: begin
            case (op_q)
               c_OP_QUERY: begin
                  state_d     = S_RSP;
                  rsp_valid_d = 1'b1;
                  rsp_count_d = ram_rdata_i;
                  rsp_ok_d    = 1'b1;
               end
               c_OP_DISP: begin
                  if (ram_rdata_i == '0) begin
                     // Empty slot: skip the write and fail.
                     state_d     = S_RSP;
                     rsp_valid_d = 1'b1;
                     rsp_count_d = '0;
                     rsp_ok_d    = 1'b0;
                  end else begin
                     state_d     = S_WR;
                     ram_we_d    = 1'b1;
                     ram_wdata_d = ram_rdata_i - c_ONE;
                     res_count_d = ram_rdata_i - c_ONE;
                     res_ok_d    = 1'b1;
                  end
               end
               c_OP_RESTOCK: begin
                  state_d  = S_WR;
                  ram_we_d = 1'b1;
                  if (w_sum[DATA_W]) begin
                     ram_wdata_d = c_MAX;
                     res_count_d = c_MAX;
                     res_ok_d    = 1'b0;
                  end else begin
                     ram_wdata_d = w_sum[DATA_W-1:0];
                     res_count_d = w_sum[DATA_W-1:0];
                     res_ok_d    = 1'b1;
                  end
               end
               default: begin
                  state_d = S_IDLE;
               end
            endcase
         end
         S_WR: begin
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
            rsp_count_d = res_count_q;
            rsp_ok_d    = res_ok_q;
         end
         S_RSP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

`ifdef VEND_LOW_STOCK_EN
   always_comb begin
      low_stock_d = low_stock_q;
      if (rsp_valid_d) begin
         low_stock_d = (rsp_count_d <= c_LOW_THRESH);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         qty_q       <= '0;
         res_count_q <= '0;
         res_ok_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_count_q <= '0;
         rsp_ok_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_re_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
`ifdef VEND_LOW_STOCK_EN
         low_stock_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         qty_q       <= qty_d;
         res_count_q <= res_count_d;
         res_ok_q    <= res_ok_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_count_q <= rsp_count_d;
         rsp_ok_q    <= rsp_ok_d;
         ram_we_q    <= ram_we_d;
         ram_re_q    <= ram_re_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
`ifdef VEND_LOW_STOCK_EN
         low_stock_q <= low_stock_d;
`endif
      end
   end

   assign req_ready_o = (state_q == S_IDLE) && !rst;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_count_o = rsp_count_q;
   assign rsp_ok_o    = rsp_ok_q;
   // The strobes are masked by rst so a reset landing in the WR (or RD)
   // cycle keeps the RAM from sampling a write that is being abandoned.
   assign ram_we_o    = ram_we_q && !rst;
   assign ram_re_o    = ram_re_q && !rst;
   assign ram_addr_o  = ram_addr_q;
   assign ram_wdata_o = ram_wdata_q;
`ifdef VEND_LOW_STOCK_EN
   assign low_stock_o = low_stock_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vend_stock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_stock_ctrl
// Purpose  : Self-checking bench for vend_stock_ctrl with a behavioural
//            registered-read slot RAM and a response scoreboard.
// Config   : VEND_LOW_STOCK_EN - also checks low_stock_o
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_stock_ctrl;

   localparam logic [1:0] OP_Q = 2'b00;
   localparam logic [1:0] OP_D = 2'b01;
   localparam logic [1:0] OP_R = 2'b10;
   localparam logic [1:0] OP_C = 2'b11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] req_op = 2'b00;
   logic [1:0] req_slot = 2'b00;
   logic [3:0] req_qty = 4'd0;
   logic       rsp_valid;
   logic [3:0] rsp_count;
   logic       rsp_ok;
   logic       ram_we, ram_re;
   logic [1:0] ram_addr;
   logic [3:0] ram_wdata;
   logic [3:0] ram_rdata = 4'd0;
`ifdef VEND_LOW_STOCK_EN
   logic       low_stock;
`endif

   vend_stock_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_op_i    (req_op),
      .req_slot_i  (req_slot),
      .req_qty_i   (req_qty),
      .rsp_valid_o (rsp_valid),
      .rsp_count_o (rsp_count),
      .rsp_ok_o    (rsp_ok),
      .ram_we_o    (ram_we),
      .ram_re_o    (ram_re),
      .ram_addr_o  (ram_addr),
      .ram_wdata_o (ram_wdata),
      .ram_rdata_i (ram_rdata)
`ifdef VEND_LOW_STOCK_EN
      ,
      .low_stock_o (low_stock)
`endif
   );

   always #5 clk = ~clk;

   // Slot RAM: registered read, contents untouched by rst.
   logic [3:0] mem [4];
   initial for (int i = 0; i < 4; i++) mem[i] = 4'd0;
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0] op;
      logic [1:0] slot;
      logic [3:0] qty;
      logic [3:0] cnt;
      logic       ok;
      int         lat;
      logic       hold;
   } vec_t;

   typedef struct {
      logic [1:0] op;
      logic [1:0] slot;
      logic [3:0] cnt;
      logic       ok;
      int         lat;
      int         hs;
   } exp_t;

   vec_t vecs [32];
   int   nv = 0;
   exp_t sbq [$];
   int   checks = 0;
   int   errors = 0;
   int   we_n = 0;
   int   re_n = 0;
   int   prev_hs = -100;
   int   prev_lat = 0;
   logic prev_hold = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic [1:0] op, input int slot, input int qty,
                      input int cnt, input logic ok, input int lat, input logic hold);
      vecs[nv].op   = op;
      vecs[nv].slot = 2'(slot);
      vecs[nv].qty  = 4'(qty);
      vecs[nv].cnt  = 4'(cnt);
      vecs[nv].ok   = ok;
      vecs[nv].lat  = lat;
      vecs[nv].hold = hold;
      nv++;
   endtask

   // Watches the RAM port and pops/compares responses.
   task automatic monitor();
      exp_t e;
      int   exp_we;
      forever begin
         @(negedge clk);
         if (rst) begin
            we_n = 0;
            re_n = 0;
         end else begin
            if (ram_we && ram_re) chk("we_re_overlap", 1, 0);
            if (ram_we) begin
               we_n++;
               if (sbq.size() > 0) begin
                  chk("wr_addr", int'(ram_addr), int'(sbq[0].slot));
                  chk("wr_data", int'(ram_wdata), int'(sbq[0].cnt));
               end
            end
            if (ram_re) begin
               re_n++;
               if (sbq.size() > 0) chk("rd_addr", int'(ram_addr), int'(sbq[0].slot));
            end
            if (rsp_valid) begin
               if (sbq.size() == 0) begin
                  chk("unexpected_rsp", 1, 0);
               end else begin
                  e = sbq.pop_front();
                  chk("rsp_count", int'(rsp_count), int'(e.cnt));
                  chk("rsp_ok", int'(rsp_ok), int'(e.ok));
                  chk("latency", cyc - e.hs, e.lat);
                  exp_we = (e.op == OP_C || e.op == OP_R || (e.op == OP_D && e.ok)) ? 1 : 0;
                  chk("we_pulses", we_n, exp_we);
                  chk("re_pulses", re_n, (e.op == OP_C) ? 0 : 1);
`ifdef VEND_LOW_STOCK_EN
                  chk("low_stock", int'(low_stock), (e.cnt <= 4'd2) ? 1 : 0);
`endif
               end
               we_n = 0;
               re_n = 0;
            end
         end
      end
   endtask

   // Waits for req_ready at a negedge; returns 0 on timeout.
   task automatic wait_ready(output logic got);
      int n = 0;
      got = 1'b1;
      while (!req_ready) begin
         n++;
         if (n > 30) begin
            chk("ready_timeout", 0, 1);
            got = 1'b0;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic do_req(input vec_t v);
      exp_t e;
      logic got;
      int   n;
      @(negedge clk);
      req_op    = v.op;
      req_slot  = v.slot;
      req_qty   = v.qty;
      req_valid = 1'b1;
      wait_ready(got);
      if (!got) begin
         req_valid = 1'b0;
         return;
      end
      if (prev_hold) chk("b2b_gap_ok", (cyc - prev_hs >= prev_lat + 1) ? 1 : 0, 1);
      e.op = v.op; e.slot = v.slot; e.cnt = v.cnt; e.ok = v.ok; e.lat = v.lat; e.hs = cyc;
      sbq.push_back(e);
      prev_hs = cyc; prev_lat = v.lat; prev_hold = v.hold;
      @(posedge clk);
      if (!v.hold) begin
         @(negedge clk);
         req_valid = 1'b0;
         n = 0;
         while (sbq.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (sbq.size() > 0) begin
            chk("rsp_timeout", 0, 1);
            sbq.delete();
         end
      end
   endtask

   initial begin
      logic got;
      int   n;
      vec_t v;
      fork
         monitor();
      join_none

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", int'(req_ready), 0);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_rsp_count", int'(rsp_count), 0);
      chk("rst_rsp_ok", int'(rsp_ok), 0);
      chk("rst_we", int'(ram_we), 0);
      chk("rst_re", int'(ram_re), 0);
      chk("rst_addr", int'(ram_addr), 0);
      chk("rst_wdata", int'(ram_wdata), 0);
`ifdef VEND_LOW_STOCK_EN
      chk("rst_low_stock", int'(low_stock), 0);
`endif
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", int'(req_ready), 1);

      //   op    slot qty cnt ok lat hold
      add(OP_C, 0, 0,  0, 1, 2, 0);
      add(OP_R, 0, 15, 15, 1, 4, 0);
      add(OP_Q, 0, 0,  15, 1, 3, 0);
      add(OP_R, 0, 0,  15, 1, 4, 0);   // qty 0 rewrites, sum==15 not saturated
      add(OP_C, 1, 0,  0, 1, 2, 0);
      add(OP_R, 1, 9,  9, 1, 4, 0);
      add(OP_R, 1, 9,  15, 0, 4, 0);   // 18 saturates
      add(OP_Q, 1, 0,  15, 1, 3, 0);
      add(OP_C, 2, 0,  0, 1, 2, 0);
      add(OP_D, 2, 0,  0, 0, 3, 0);    // empty slot: no write
      add(OP_C, 3, 0,  0, 1, 2, 0);
      add(OP_R, 3, 3,  3, 1, 4, 0);
      add(OP_D, 3, 0,  2, 1, 4, 0);
      add(OP_D, 3, 0,  1, 1, 4, 0);
      add(OP_D, 3, 0,  0, 1, 4, 0);
      add(OP_D, 3, 0,  0, 0, 3, 0);
      add(OP_R, 2, 15, 15, 1, 4, 0);
      add(OP_R, 2, 1,  15, 0, 4, 0);
      // Back-to-back with req_valid held high
      add(OP_Q, 1, 0,  15, 1, 3, 1);
      add(OP_D, 1, 0,  14, 1, 4, 1);
      add(OP_C, 0, 0,  0, 1, 2, 1);
      add(OP_R, 0, 7,  7, 1, 4, 1);
      add(OP_Q, 1, 0,  14, 1, 3, 0);
      // Setup for the reset-abort sequence
      add(OP_C, 1, 0,  0, 1, 2, 0);
      add(OP_R, 1, 5,  5, 1, 4, 0);

      for (int i = 0; i < nv; i++) do_req(vecs[i]);
      prev_hold = 1'b0;

      // Reset during the WR cycle of restock slot 1 qty 4 (count 5)
      @(negedge clk);
      req_op = OP_R; req_slot = 2'd1; req_qty = 4'd4; req_valid = 1'b1;
      wait_ready(got);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!ram_we && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("abort_wr_seen", int'(ram_we), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_rsp_valid", int'(rsp_valid), 0);
      chk("abort_we", int'(ram_we), 0);
      chk("abort_re", int'(ram_re), 0);
      chk("abort_addr", int'(ram_addr), 0);
      chk("abort_wdata", int'(ram_wdata), 0);
      chk("abort_rsp_count", int'(rsp_count), 0);
      chk("abort_rsp_ok", int'(rsp_ok), 0);
      chk("abort_ready", int'(req_ready), 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      v.op = OP_Q; v.slot = 2'd1; v.qty = 4'd0; v.cnt = 4'd5; v.ok = 1'b1; v.lat = 3; v.hold = 1'b0;
      do_req(v);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
